// File: rtl/transmitter_pkg.sv
// transmitter_pkg -- shared frame constants and FSM state type.
//   Used by transmitter, tx_frame_mux and the matching receiver.
//   FRAME_LEN : bytes per frame
//   IDX_W     : width of the byte index within a frame
//   PREFIX    : 0xAA, the receiver's lead-in byte (closes a transmitted frame)
//   SUFFIX    : 0x55, the receiver's trailer byte (opens a transmitted frame)
//   tx_state_e: IDLE / WAIT_SPACE / SEND
// Optional feature macro: TX_CHECKSUM_EN (adds frame_checksum helper).
package transmitter_pkg;

    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned IDX_W     = 3;

    localparam logic [7:0] PREFIX = 8'hAA;
    localparam logic [7:0] SUFFIX = 8'h55;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        SEND       = 2'd2
    } tx_state_e;

`ifdef TX_CHECKSUM_EN
    // XOR of the code byte and the four payload bytes.
    function automatic logic [7:0] frame_checksum(input logic [7:0]  code,
                                                  input logic [31:0] data);
        return code ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24];
    endfunction
`endif

endpackage

// File: rtl/transmitter_frame_mux.sv
// tx_frame_mux -- selects the byte of the latched frame at a given index.
//   idx_i  : byte index 0..7 within the frame
//   code_i : latched frame code byte
//   data_i : latched 32-bit payload
//   byte_o : frame byte at idx_i
// Byte order: 0x55, data[7:0], data[15:8], data[23:16], data[31:24],
//             code, TAIL, 0xAA.
// Macro TX_CHECKSUM_EN: TAIL = XOR of code and data bytes; otherwise 0x00.
module tx_frame_mux
    import transmitter_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic [7:0]       code_i,
    input  logic [31:0]      data_i,
    output logic [7:0]       byte_o
);

    logic [7:0] tail;

`ifdef TX_CHECKSUM_EN
    assign tail = frame_checksum(code_i, data_i);
`else
    assign tail = 8'h00;
`endif

    // A transmitted frame opens with SUFFIX and closes with PREFIX; the
    // names are the receiver's, which sees the stream from the other end.
    always_comb begin
        byte_o = 8'h00;
        unique case (idx_i)
            3'd0: byte_o = SUFFIX;
            3'd1: byte_o = data_i[7:0];
            3'd2: byte_o = data_i[15:8];
            3'd3: byte_o = data_i[23:16];
            3'd4: byte_o = data_i[31:24];
            3'd5: byte_o = code_i;
            3'd6: byte_o = tail;
            3'd7: byte_o = PREFIX;
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/transmitter.sv
// transmitter -- serialises a response command into an 8-byte frame
// written into a TX FIFO.
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_code/cmd_data : command handshake and payload
//   txfifo_load  : TX FIFO occupancy; a frame starts only with room for 8 bytes
//   txfifo_full  : TX FIFO cannot accept a byte this cycle
//   txfifo_wr    : write strobe, txfifo_data : byte written
//   busy         : state is not IDLE
//   frames_sent  : completed frames, modulo 2^16
// Macro TX_CHECKSUM_EN (in tx_frame_mux): checksum in the TAIL byte.
module transmitter
    import transmitter_pkg::*;
#(
    parameter int unsigned TX_FIFO_LOAD_W = 13,
    parameter int unsigned TX_FIFO_DEPTH  = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [7:0]                cmd_code,
    input  logic [31:0]               cmd_data,
    input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
    input  logic                      txfifo_full,
    output logic                      txfifo_wr,
    output logic [7:0]                txfifo_data,
    output logic                      busy,
    output logic [15:0]               frames_sent
);

    localparam logic [TX_FIFO_LOAD_W-1:0] SPACE_LIMIT =
        TX_FIFO_LOAD_W'(TX_FIFO_DEPTH - FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    tx_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       code_q, code_d;
    logic [31:0]      data_q, data_d;
    logic [15:0]      frames_sent_q, frames_sent_d;
    logic             frame_done;
    logic             accept;
    logic [7:0]       mux_byte;

    // cmd_ready is gated by rst so it stays low for the whole reset pulse.
    assign cmd_ready     = (state_q == IDLE) && !rst;
    assign accept        = cmd_valid && cmd_ready;
    assign txfifo_wr     = (state_q == SEND) && !txfifo_full;
    assign busy          = (state_q != IDLE);
    assign frames_sent   = frames_sent_q;
    assign frames_sent_d = frames_sent_q + 16'd1;
    // Outside SEND the data bus idles at zero.
    assign txfifo_data   = (state_q == SEND) ? mux_byte : 8'h00;

    tx_frame_mux u_frame_mux (
        .idx_i  (idx_q),
        .code_i (code_q),
        .data_i (data_q),
        .byte_o (mux_byte)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        code_d     = code_q;
        data_d     = data_q;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    code_d  = cmd_code;
                    data_d  = cmd_data;
                    idx_d   = '0;
                    state_d = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (txfifo_load <= SPACE_LIMIT) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (txfifo_wr) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            code_q        <= '0;
            data_q        <= '0;
            frames_sent_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            data_q  <= data_d;
            if (frame_done) begin
                frames_sent_q <= frames_sent_d;
            end
        end
    end

endmodule

// File: tb/tb_transmitter.sv
module tb_transmitter;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic [12:0] txfifo_load;
    logic        txfifo_full;
    logic        txfifo_wr;
    logic [7:0]  txfifo_data;
    logic        busy;
    logic [15:0] frames_sent;

    transmitter #(
        .TX_FIFO_LOAD_W (13),
        .TX_FIFO_DEPTH  (4096)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_data    (cmd_data),
        .txfifo_load (txfifo_load),
        .txfifo_full (txfifo_full),
        .txfifo_wr   (txfifo_wr),
        .txfifo_data (txfifo_data),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int unsigned wr_count;
    int unsigned pos;
    logic [7:0]  wr_log [8];
    logic [7:0]  exp_q [$];
    logic [15:0] exp_frames;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference frame: built directly from the byte-order rule.
    function automatic void push_frame(input logic [7:0] c, input logic [31:0] d);
        logic [7:0] tail;
`ifdef TX_CHECKSUM_EN
        tail = c ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
`else
        tail = 8'h00;
`endif
        exp_q.push_back(8'h55);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(c);
        exp_q.push_back(tail);
        exp_q.push_back(8'hAA);
        exp_frames = exp_frames + 16'd1;
    endfunction

    // Called and returns at posedge+1; the command is accepted on the
    // posedge inside the task.
    task automatic send_cmd(input logic [7:0] c, input logic [31:0] d);
        int unsigned n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_code  = c;
        cmd_data  = d;
        push_frame(c, d);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_code  = 8'($urandom);
        cmd_data  = $urandom;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic frame_end_checks(input string name);
        check({name, "_frames_sent"}, {16'd0, frames_sent}, {16'd0, exp_frames});
        check({name, "_queue_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int unsigned nw, gaps, fullc, base, viol;
        checks      = 0;
        errors      = 0;
        wr_count    = 0;
        pos         = 0;
        exp_frames  = 16'd0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_code    = 8'h00;
        cmd_data    = 32'h0;
        txfifo_load = 13'd0;
        txfifo_full = 1'b0;

        fork
            // Scoreboard monitor: every write pops one expected byte.
            forever begin
                @(negedge clk);
                if (rst) pos = 0;
                if (txfifo_wr) begin
                    wr_count++;
                    wr_log[pos] = txfifo_data;
                    pos = (pos + 1) % 8;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: got=%02h expected=no write", txfifo_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (txfifo_data !== e) begin
                            errors++;
                            $display("FAIL frame_byte: got=%02h expected=%02h", txfifo_data, e);
                        end
                    end
                end
            end
            begin
                #1000000;
                $display("FAIL watchdog: got=timeout expected=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr", {31'd0, txfifo_wr}, 32'd0);
        check("rst_data", {24'd0, txfifo_data}, 32'd0);
        check("rst_frames", {16'd0, frames_sent}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;

        // Basic frame with latency and back-to-back writes
        send_cmd(8'h01, 32'h0001_0123);
        @(negedge clk);
        check("basic_no_early_wr", {31'd0, txfifo_wr}, 32'd0);
        check("basic_busy", {31'd0, busy}, 32'd1);
        check("basic_ready_low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("basic_first_wr", {31'd0, txfifo_wr}, 32'd1);
        nw = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (txfifo_wr) nw++;
        end
        check("basic_consecutive_wr", nw, 32'd7);
        @(posedge clk); #1;
        check("basic_idle_after", {31'd0, busy}, 32'd0);
        frame_end_checks("basic");

        // Backpressure: full for 3 cycles after byte 2
        send_cmd(8'h01, 32'h0001_0123);
        nw = 0; gaps = 0; fullc = 0;
        for (int cyc = 0; cyc < 40 && nw < 8; cyc++) begin
            @(negedge clk);
            if (txfifo_wr) nw++;
            else if (nw > 0) gaps++;
            if (txfifo_full) check("bp_data_held", {24'd0, txfifo_data}, 32'h01);
            @(posedge clk); #1;
            if (nw == 3 && fullc < 3) begin
                txfifo_full = 1'b1;
                fullc++;
            end else begin
                txfifo_full = 1'b0;
            end
        end
        txfifo_full = 1'b0;
        check("bp_writes", nw, 32'd8);
        check("bp_stall_cycles", gaps, 32'd3);
        frame_end_checks("bp");

        // Space gating, including the 4089 boundary
        txfifo_load = 13'd4090;
        send_cmd(8'h5A, 32'hDEAD_BEEF);
        base = wr_count;
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) txfifo_load = 13'd4089;
            @(negedge clk);
            if (txfifo_wr) viol++;
            @(posedge clk); #1;
        end
        check("gate_no_writes", viol, 32'd0);
        check("gate_busy", {31'd0, busy}, 32'd1);
        txfifo_load = 13'd4088;
        @(negedge clk);
        check("gate_not_yet", {31'd0, txfifo_wr}, 32'd0);
        @(negedge clk);
        check("gate_start", {31'd0, txfifo_wr}, 32'd1);
        wait_idle();
        txfifo_load = 13'd0;
        frame_end_checks("gate");

        // Tail byte
        send_cmd(8'h03, 32'h0000_0023);
        wait_idle();
`ifdef TX_CHECKSUM_EN
        check("tail_byte", {24'd0, wr_log[6]}, 32'h20);
`else
        check("tail_byte", {24'd0, wr_log[6]}, 32'h00);
`endif
        frame_end_checks("tail");

        // Reset mid-frame after byte 4
        send_cmd(8'h77, 32'h1234_5678);
        base = wr_count;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); #1;
            if (wr_count >= base + 5) break;
        end
        check("rst_mid_progress", wr_count - base, 32'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        exp_frames = 16'd0;
        @(negedge clk);
        check("rst_mid_wr", {31'd0, txfifo_wr}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_mid_frames", {16'd0, frames_sent}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        base = wr_count;
        @(negedge clk);
        check("rst_mid_ready_after", {31'd0, cmd_ready}, 32'd1);
        repeat (5) @(negedge clk);
        #1;
        check("rst_mid_no_writes", wr_count - base, 32'd0);
        @(posedge clk); #1;
        send_cmd(8'hC3, 32'hA5A5_0F0F);
        wait_idle();
        frame_end_checks("rst_recover");

        // Counter wrap
        @(negedge clk);
        force dut.frames_sent_q = 16'hFFFF;
        #1;
        release dut.frames_sent_q;
        #1;
        check("wrap_preload", {16'd0, frames_sent}, 32'hFFFF);
        exp_frames = 16'hFFFF;
        @(posedge clk); #1;
        send_cmd(8'h11, 32'h2233_4455);
        wait_idle();
        check("wrap_zero", {16'd0, frames_sent}, 32'h0000);
        frame_end_checks("wrap");

        // Random frames with random stalls and FIFO occupancy
        for (int f = 0; f < 25; f++) begin
            send_cmd(8'($urandom), $urandom);
            viol = 0;
            for (int n = 0; n < 500; n++) begin
                @(negedge clk);
                if (cmd_ready === busy) viol++;
                if (!busy) break;
                @(posedge clk); #1;
                txfifo_full = ($urandom_range(0, 3) == 0);
                txfifo_load = ($urandom_range(0, 4) == 0) ? 13'd4095
                                                          : 13'($urandom_range(0, 4088));
            end
            check("rand_idle", {31'd0, busy}, 32'd0);
            check("rand_ready_vs_busy", viol, 32'd0);
            @(posedge clk); #1;
            txfifo_full = 1'b0;
            txfifo_load = 13'd0;
            frame_end_checks("rand");
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/transmitter.md
TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 SHALL have parameter TX_FIFO_LOAD_W, default 13, giving the width of the TX FIFO fill-level input.
REQ-002 SHALL have parameter TX_FIFO_DEPTH, default 4096, giving the TX FIFO capacity in bytes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a response command is offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the command is accepted on a cycle with cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_code, input, 8 bits: frame code byte.
REQ-008 SHALL have port cmd_data, input, 32 bits: frame payload.
REQ-009 SHALL have port txfifo_load, input, TX_FIFO_LOAD_W bits: current TX FIFO occupancy.
REQ-010 SHALL have port txfifo_full, input, 1 bit: the TX FIFO cannot take a byte this cycle.
REQ-011 SHALL have port txfifo_wr, output, 1 bit: write strobe to the TX FIFO.
REQ-012 SHALL have port txfifo_data, output, 8 bits: byte written when txfifo_wr is high.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port frames_sent, output, 16 bits: count of completed frames.

Function
REQ-015 SHALL emit every frame as 8 bytes in the order 0x55, data[7:0], data[15:8], data[23:16], data[31:24], code, TAIL, 0xAA, where TAIL is 0x00 unless REQ-029 applies.
REQ-016 SHALL implement states IDLE, WAIT_SPACE and SEND.
REQ-017 SHALL assert cmd_ready only in IDLE; on accept it SHALL latch code and data and enter WAIT_SPACE.
REQ-018 SHALL leave WAIT_SPACE for SEND at the first edge where txfifo_load <= TX_FIFO_DEPTH-8; otherwise it SHALL hold with txfifo_wr low.
REQ-019 SHALL drive txfifo_wr combinationally as (state==SEND) && !txfifo_full.
REQ-020 SHALL advance the 3-bit byte index only on cycles where txfifo_wr is high.
REQ-021 SHALL hold the index and txfifo_data unchanged while txfifo_full is high mid-frame, with no byte dropped or duplicated.
REQ-022 SHALL drive txfifo_data from the latched frame, so later cmd_* changes do not affect the frame in flight.
REQ-023 SHALL assert the first txfifo_wr in the second cycle after the accepting edge when space is available; with no stalls, it SHALL issue 8 writes on consecutive cycles.
REQ-024 SHALL, on the edge that writes byte 7, return to IDLE and increment frames_sent modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-025 SHALL ignore cmd_valid outside IDLE; back-to-back frames are separated by at least one IDLE cycle.

Reset
REQ-026 SHALL, while rst is high, force state IDLE, index 0, frames_sent 0, latched frame 0, txfifo_data 0x00, txfifo_wr 0, busy 0 and cmd_ready 0.
REQ-027 SHALL abandon a partially sent frame when rst asserts mid-frame, with no further bytes written after reset is released.
REQ-028 SHALL assert cmd_ready in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, when macro TX_CHECKSUM_EN is defined, set TAIL to the XOR of code and the four data bytes.
REQ-030 SHALL, when TX_CHECKSUM_EN is undefined, set TAIL to 0x00 and contain no checksum logic.

Structure
REQ-031 SHALL take the frame constants (PREFIX 0xAA, SUFFIX 0x55, FRAME_LEN 8) and the state enum from a shared package also used by receiver.
REQ-032 SHALL place the byte-select/checksum mux in one sub-module, tx_frame_mux.

Verification
REQ-033 SHALL verify a basic frame: code 0x01, data 0x00010123, load 0 -> bytes 55,23,01,01,00,01,00,AA on 8 consecutive writes, and frames_sent becomes 1.
REQ-034 SHALL verify backpressure: txfifo_full pulsed high for 3 cycles after byte 2 -> stream identical to REQ-033, with txfifo_wr low for exactly those 3 cycles.
REQ-035 SHALL verify space gating: load 4090 with depth 4096 -> no writes; load drops to 4088 -> frame starts 1 cycle later.
REQ-036 SHALL verify checksum: with TX_CHECKSUM_EN, code 0x03, data 0x00000023 -> TAIL byte 0x20; without the macro -> TAIL 0x00.
REQ-037 SHALL verify reset mid-frame: rst after byte 4 -> no further writes, frames_sent 0, cmd_ready high after release, next frame complete and correct.
REQ-038 SHALL verify counter wrap: preload 0xFFFF frames (forced), send one frame -> frames_sent 0x0000.
